snd_cmd_irq_ctrl: RTL

Parametrised sound-CPU command/interrupt controller for the sound subsystem. Main CPU command bytes go into a CMD_DEPTH-deep FIFO instead of a single latch. It latches falling-edge IRQs from N_CHIPS FM chips, exposes a status register with write-zero-to-acknowledge, and drives the sound Z80 INT_n and the MS busy flag back to the main CPU.

---
 rtl/snd_cmd_irq_ctrl.sv | 91 +++++++++
 1 files changed

// File: rtl/snd_cmd_irq_ctrl.sv
// snd_cmd_irq_ctrl: sound-CPU command FIFO, FM chip IRQ latching, status/ack port, INT_n and busy flag
module snd_cmd_irq_ctrl #(
    parameter int N_CHIPS   = 2,
    parameter int CMD_DEPTH = 4,
    parameter int CW        = $clog2(CMD_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               RESETn,
    input  logic               mcode_we,
    input  logic [7:0]         mcode_din,
    input  logic [N_CHIPS-1:0] chip_irq_n,
    input  logic               cs_cmd,
    input  logic               cs_status,
    input  logic               rd,
    input  logic               wr,
    input  logic [7:0]         cpu_dout,
    output logic [7:0]         rd_data,
    output logic               int_n,
    output logic               ms,
    output logic [CW-1:0]      cmd_count,
    output logic               cmd_full
);
    localparam int AW = $clog2(CMD_DEPTH);
    logic [7:0]         mem [CMD_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count_nx;
    logic [N_CHIPS-1:0] chip_lat, prev_n, lat_nx;
    logic               busy, ovf, busy_nx, ovf_nx;
    logic               acc_q, acc_ok, st_wr_q;
    logic               cmd_acc, st_rd, st_wr, st_we, empty, full, pop, push_ok;
    logic [7:0]         status, rd_nx;
    // Access decode, FIFO bookkeeping, acknowledge masks (set beats clear) and read mux
    always_comb begin
        cmd_acc  = cs_cmd & rd;
        st_rd    = cs_status & rd & ~cs_cmd;
        st_wr    = cs_status & wr & ~cs_cmd;
        st_we    = st_wr & ~st_wr_q;
        empty    = cmd_count == '0;
        full     = cmd_count == CW'(CMD_DEPTH);
        pop      = acc_q & ~cmd_acc & acc_ok;
        push_ok  = mcode_we & (~full | pop);
        count_nx = cmd_count + CW'(push_ok) - CW'(pop);
        status   = 8'hFF;
        status[N_CHIPS-1:0] = chip_lat;
        status[N_CHIPS]     = busy;
        status[N_CHIPS+1]   = ~empty;
        status[7]           = ovf;
        lat_nx   = (prev_n & ~chip_irq_n) | (chip_lat & ~(st_we ? ~cpu_dout[N_CHIPS-1:0] : '0));
        busy_nx  = mcode_we | (busy & ~(st_we & ~cpu_dout[N_CHIPS]));
        ovf_nx   = (mcode_we & full & ~pop) | (ovf & ~(st_we & ~cpu_dout[7]));
        rd_nx    = cmd_acc ? (acc_q ? rd_data : (empty ? 8'hFF : mem[rd_ptr])) : st_rd ? status : 8'hFF;
    end
    // Command storage; contents are not reset
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= mcode_din;
    end
    // Control state, pointers and registered outputs
    always_ff @(posedge clk) begin
        if (!RESETn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cmd_count <= '0;
            cmd_full  <= 1'b0;
            chip_lat  <= '0;
            prev_n    <= '1;
            busy      <= 1'b0;
            ovf       <= 1'b0;
            acc_q     <= 1'b0;
            acc_ok    <= 1'b0;
            st_wr_q   <= 1'b0;
            rd_data   <= 8'hFF;
            int_n     <= 1'b1;
            ms        <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (cmd_acc & ~acc_q) acc_ok <= ~empty;
            cmd_count <= count_nx;
            cmd_full  <= count_nx == CW'(CMD_DEPTH);
            chip_lat  <= lat_nx;
            prev_n    <= chip_irq_n;
            busy      <= busy_nx;
            ovf       <= ovf_nx;
            acc_q     <= cmd_acc;
            st_wr_q   <= st_wr;
            rd_data   <= rd_nx;
            int_n     <= ~(|chip_lat | ~empty);
            ms        <= busy;
        end
    end
endmodule
